// File: rtl/iir_mux_scheduler_if.sv
// Channel intake, coefficient config and result bus of the time-multiplexed IIR scheduler.
// The master side drives samples and config; the slave side (the scheduler) returns results.
interface iir_mux_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]    ch_valid_i;
    logic [NUM_CH*16-1:0] ch_data_i;
    logic [NUM_CH-1:0]    ch_ready_o;
    logic                 cfg_we_i;
    logic [1:0]           cfg_addr_i;
    logic [17:0]          cfg_data_i;
    logic                 clear_i;
    logic                 out_valid_o;
    logic [CH_W-1:0]      out_ch_o;
    logic [15:0]          data_o;
    logic                 busy_o;

    modport master (
        output ch_valid_i, ch_data_i, cfg_we_i, cfg_addr_i, cfg_data_i, clear_i,
        input  ch_ready_o, out_valid_o, out_ch_o, data_o, busy_o
    );

    modport slave (
        input  ch_valid_i, ch_data_i, cfg_we_i, cfg_addr_i, cfg_data_i, clear_i,
        output ch_ready_o, out_valid_o, out_ch_o, data_o, busy_o
    );
endinterface

// File: rtl/iir_mux_scheduler.sv
// First-order IIR engine shared round-robin across NUM_CH channels using one 18x18 multiplier.
// Each grant runs IDLE -> MUL_B0 -> MUL_B1 -> MUL_A1 -> SAT with a latched coefficient snapshot.
module iir_mux_scheduler #(
    parameter int                 NUM_CH      = 4,
    parameter logic signed [17:0] COEF_B0_RST = 18'sd32767,
    parameter logic signed [17:0] COEF_B1_RST = -18'sd32768,
    parameter logic signed [17:0] COEF_A1_RST = 18'sd0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    iir_mux_scheduler_if.slave    bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_B0 = 3'd1,
        MUL_B1 = 3'd2,
        MUL_A1 = 3'd3,
        SAT    = 3'd4
    } state_e;

    state_e             state_q;
    logic [NUM_CH-1:0]  pending_q;
    logic signed [17:0] x_q     [NUM_CH];
    logic signed [17:0] xprev_q [NUM_CH];
    logic signed [17:0] yprev_q [NUM_CH];

    logic signed [17:0] b0_q, b1_q, a1_q;
    logic signed [17:0] b0_sh_q, b1_sh_q, a1_sh_q;

    logic [CH_W-1:0]    rr_q;
    logic [CH_W-1:0]    grant_q;
    logic [CH_W-1:0]    grant_d;
    logic               grant_found_d;
    logic [CH_W:0]      idx_s;
    logic [CH_W:0]      sel_s;

    logic signed [37:0] acc_q;
    logic signed [37:0] acc_d;
    logic signed [17:0] mul_a_s;
    logic signed [17:0] mul_b_s;
    logic signed [35:0] prod_s;
    logic signed [35:0] prod_sh_s;
    logic signed [37:0] term_s;
    logic signed [17:0] sat_s;
    logic               clear_req_s;

    logic               clr_pend_q;
    logic               out_valid_q;
    logic [CH_W-1:0]    out_ch_q;
    logic [15:0]        data_q;
    logic               busy_q;

    function automatic logic signed [17:0] sat18(input logic signed [37:0] v);
        logic signed [17:0] r;
        if (v > 38'sd131071) begin
            r = 18'sd131071;
        end else if (v < -38'sd131072) begin
            r = -18'sd131072;
        end else begin
            r = v[17:0];
        end
        return r;
    endfunction

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        logic [CH_W-1:0] r;
        if (c == LAST_CH) begin
            r = '0;
        end else begin
            r = c + CH_W'(1);
        end
        return r;
    endfunction

    // Round-robin search: first pending channel at or after rr_q, wrapping.
    always_comb begin
        grant_found_d = 1'b0;
        grant_d       = rr_q;
        idx_s         = '0;
        sel_s         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_s = {1'b0, rr_q} + (CH_W+1)'(i);
            if (idx_s >= (CH_W+1)'(NUM_CH)) begin
                sel_s = idx_s - (CH_W+1)'(NUM_CH);
            end else begin
                sel_s = idx_s;
            end
            if (!grant_found_d && pending_q[sel_s[CH_W-1:0]]) begin
                grant_found_d = 1'b1;
                grant_d       = sel_s[CH_W-1:0];
            end else begin
                grant_found_d = grant_found_d;
            end
        end
    end

    // Shared multiplier operand select and accumulator next state.
    always_comb begin
        mul_a_s = 18'sd0;
        mul_b_s = 18'sd0;
        acc_d   = acc_q;
        case (state_q)
            MUL_B0: begin
                mul_a_s = b0_sh_q;
                mul_b_s = x_q[grant_q];
                acc_d   = term_s;
            end
            MUL_B1: begin
                mul_a_s = b1_sh_q;
                mul_b_s = xprev_q[grant_q];
                acc_d   = acc_q + term_s;
            end
            MUL_A1: begin
                mul_a_s = a1_sh_q;
                mul_b_s = yprev_q[grant_q];
                acc_d   = acc_q - term_s;
            end
            default: begin
                mul_a_s = 18'sd0;
                mul_b_s = 18'sd0;
                acc_d   = acc_q;
            end
        endcase
    end

    assign prod_s      = mul_a_s * mul_b_s;
    assign prod_sh_s   = prod_s >>> 17;
    assign term_s      = {{2{prod_sh_s[35]}}, prod_sh_s};
    assign sat_s       = sat18(acc_q);
    assign clear_req_s = bus.clear_i | clr_pend_q;

    // Sample intake; a channel's pending flag drops at its own SAT write-back.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                x_q[k] <= 18'sd0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ((state_q == SAT) && (grant_q == CH_W'(k))) begin
                    pending_q[k] <= 1'b0;
                end else if (bus.ch_valid_i[k] && !pending_q[k]) begin
                    pending_q[k] <= 1'b1;
                    x_q[k]       <= {bus.ch_data_i[16*k +: 16], 2'b00};
                end
            end
        end
    end

    // Live coefficient registers, written straight from the config port.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            b0_q <= COEF_B0_RST;
            b1_q <= COEF_B1_RST;
            a1_q <= COEF_A1_RST;
        end else if (bus.cfg_we_i) begin
            case (bus.cfg_addr_i)
                2'd0:    b0_q <= bus.cfg_data_i;
                2'd1:    b1_q <= bus.cfg_data_i;
                2'd2:    a1_q <= bus.cfg_data_i;
                default: b0_q <= b0_q;
            endcase
        end
    end

    // Scheduler FSM with history write-back and registered result outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            acc_q       <= 38'sd0;
            b0_sh_q     <= COEF_B0_RST;
            b1_sh_q     <= COEF_B1_RST;
            a1_sh_q     <= COEF_A1_RST;
            clr_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            data_q      <= 16'h0000;
            busy_q      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                xprev_q[k] <= 18'sd0;
                yprev_q[k] <= 18'sd0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_found_d) begin
                        grant_q <= grant_d;
                        b0_sh_q <= b0_q;
                        b1_sh_q <= b1_q;
                        a1_sh_q <= a1_q;
                        state_q <= MUL_B0;
                        busy_q  <= 1'b1;
                    end
                    if (clear_req_s) begin
                        clr_pend_q <= 1'b0;
                        for (int k = 0; k < NUM_CH; k++) begin
                            xprev_q[k] <= 18'sd0;
                            yprev_q[k] <= 18'sd0;
                        end
                    end
                end
                MUL_B0, MUL_B1, MUL_A1: begin
                    acc_q      <= acc_d;
                    clr_pend_q <= clear_req_s;
                    if (state_q == MUL_B0) begin
                        state_q <= MUL_B1;
                    end else if (state_q == MUL_B1) begin
                        state_q <= MUL_A1;
                    end else begin
                        state_q <= SAT;
                    end
                end
                SAT: begin
                    // A clear seen during this computation overrides its own write-back.
                    if (clear_req_s) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            xprev_q[k] <= 18'sd0;
                            yprev_q[k] <= 18'sd0;
                        end
                    end else begin
                        xprev_q[grant_q] <= x_q[grant_q];
                        yprev_q[grant_q] <= sat_s;
                    end
                    clr_pend_q  <= 1'b0;
                    data_q      <= sat_s[17:2];
                    out_ch_q    <= grant_q;
                    out_valid_q <= 1'b1;
                    rr_q        <= next_ch(grant_q);
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ch_ready_o  = ~pending_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_ch_o    = out_ch_q;
    assign bus.data_o      = data_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_iir_mux_scheduler.sv
// Directed and randomized checks of iir_mux_scheduler against a plain-arithmetic channel model.
module tb_iir_mux_scheduler;
    localparam int NUM_CH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iir_mux_scheduler_if #(.NUM_CH(NUM_CH)) bus ();
    iir_mux_scheduler #(.NUM_CH(NUM_CH)) dut (.clk_i(clk), .reset_i(rst), .bus(bus.slave));

    int tests = 0;
    int fails = 0;

    longint mb0, mb1, ma1;
    longint xp [NUM_CH];
    longint yp [NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        mb0 = 32767;
        mb1 = -32768;
        ma1 = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            xp[k] = 0;
            yp[k] = 0;
        end
    endtask

    task automatic mdl_clear();
        for (int k = 0; k < NUM_CH; k++) begin
            xp[k] = 0;
            yp[k] = 0;
        end
    endtask

    // y = floor(b0*x/2^17) + floor(b1*xprev/2^17) - floor(a1*yprev/2^17), clamped to 18 bits.
    function automatic logic [15:0] mdl_step(input int ch, input logic [15:0] x16,
                                             input longint c0, input longint c1, input longint c2);
        longint x, acc, s;
        x   = longint'($signed(x16)) * 4;
        acc = ((c0 * x) >>> 17) + ((c1 * xp[ch]) >>> 17) - ((c2 * yp[ch]) >>> 17);
        if (acc > 131071) s = 131071;
        else if (acc < -131072) s = -131072;
        else s = acc;
        xp[ch] = x;
        yp[ch] = s;
        return 16'(s >>> 2);
    endfunction

    function automatic longint s18(input logic [17:0] d);
        return longint'($signed(d));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [17:0] d);
        bus.cfg_we_i   = 1'b1;
        bus.cfg_addr_i = a;
        bus.cfg_data_i = d;
        tick();
        bus.cfg_we_i = 1'b0;
        if (a == 2'd0) mb0 = s18(d);
        else if (a == 2'd1) mb1 = s18(d);
        else if (a == 2'd2) ma1 = s18(d);
    endtask

    task automatic pulse_clear();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
    endtask

    task automatic put(input int ch, input logic [15:0] d);
        bus.ch_data_i[16*ch +: 16] = d;
        bus.ch_valid_i[ch]         = 1'b1;
        tick();
        bus.ch_valid_i = '0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.out_valid_o !== 1'b1 && n < 40);
    endtask

    task automatic one(input string tag, input int ch, input logic [15:0] d, output logic [15:0] got);
        int n;
        logic [15:0] e;
        put(ch, d);
        wait_out(n);
        e = mdl_step(ch, d, mb0, mb1, ma1);
        check({tag, "_lat"}, n, 5);
        check({tag, "_ch"}, 32'(bus.out_ch_o), ch);
        check({tag, "_data"}, 32'(bus.data_o), 32'(e));
        got = bus.data_o;
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] e;
        logic [15:0] dv [NUM_CH];
        int n;
        int seen;

        rst            = 1'b1;
        bus.ch_valid_i = '0;
        bus.ch_data_i  = '0;
        bus.cfg_we_i   = 1'b0;
        bus.cfg_addr_i = 2'd0;
        bus.cfg_data_i = 18'd0;
        bus.clear_i    = 1'b0;
        mdl_reset();
        repeat (3) tick();
        check("rst_valid", 32'(bus.out_valid_o), 0);
        check("rst_data", 32'(bus.data_o), 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_ready", 32'(bus.ch_ready_o), 32'hF);
        rst = 1'b0;
        tick();

        // Default coefficients on channel 0.
        one("dflt_a", 0, 16'h4000, got);
        check("dflt_a_lit", 32'(got), 32'h0FFF);
        one("dflt_b", 0, 16'h4000, got);
        check("dflt_b_lit", 32'(got), 32'hFFFF);

        cfg_write(2'd0, 18'h1FFFF);
        cfg_write(2'd1, 18'h00000);
        cfg_write(2'd2, 18'h00000);
        cfg_write(2'd3, 18'h2AAAA);
        one("b0max", 1, 16'h4000, got);
        check("b0max_lit", 32'(got), 32'h3FFF);

        // Saturation in both directions.
        cfg_write(2'd1, 18'h1FFFF);
        one("psat_a", 2, 16'h7FFF, got);
        one("psat_b", 2, 16'h7FFF, got);
        check("psat_lit", 32'(got), 32'h7FFF);
        pulse_clear();
        mdl_clear();
        one("nsat_a", 2, 16'h8000, got);
        one("nsat_b", 2, 16'h8000, got);
        check("nsat_lit", 32'(got), 32'h8000);

        // All channels at once, after steering the round-robin pointer back to 0.
        one("pre3", 3, 16'($urandom), got);
        for (int k = 0; k < NUM_CH; k++) begin
            dv[k] = 16'($urandom);
            bus.ch_data_i[16*k +: 16] = dv[k];
        end
        bus.ch_valid_i = '1;
        tick();
        bus.ch_valid_i = '0;
        check("all_ready_low", 32'(bus.ch_ready_o), 0);
        for (int k = 0; k < NUM_CH; k++) begin
            wait_out(n);
            e = mdl_step(k, dv[k], mb0, mb1, ma1);
            check("all_lat", n, 5);
            check("all_ch", 32'(bus.out_ch_o), k);
            check("all_data", 32'(bus.data_o), 32'(e));
            check("all_ready", 32'(bus.ch_ready_o), (32'd1 << (k + 1)) - 32'd1);
        end

        // Coefficient write mid-computation affects only the next grant.
        cfg_write(2'd0, 18'h10000);
        cfg_write(2'd1, 18'h08000);
        cfg_write(2'd2, 18'h04000);
        dv[0] = 16'($urandom);
        put(2, dv[0]);
        tick();
        tick();
        bus.cfg_we_i   = 1'b1;
        bus.cfg_addr_i = 2'd0;
        bus.cfg_data_i = 18'd0;
        tick();
        bus.cfg_we_i = 1'b0;
        wait_out(n);
        e = mdl_step(2, dv[0], mb0, mb1, ma1);
        mb0 = 0;
        check("shadow_lat", n, 2);
        check("shadow_data", 32'(bus.data_o), 32'(e));
        one("shadow_next", 2, 16'($urandom), got);

        // Clear while busy is deferred past the write-back and then wins.
        cfg_write(2'd0, 18'h0C000);
        one("clrb_prime", 1, 16'($urandom), got);
        dv[0] = 16'($urandom);
        put(1, dv[0]);
        tick();
        pulse_clear();
        wait_out(n);
        e = mdl_step(1, dv[0], mb0, mb1, ma1);
        mdl_clear();
        check("clrb_lat", n, 3);
        check("clrb_data", 32'(bus.data_o), 32'(e));
        one("clrb_after", 1, 16'($urandom), got);

        // Randomized coefficient writes, clears and samples.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(2, 0) == 0) cfg_write(2'($urandom), 18'($urandom));
            if ($urandom_range(5, 0) == 0) begin
                pulse_clear();
                mdl_clear();
            end
            one("rnd", int'($urandom_range(NUM_CH - 1, 0)), 16'($urandom), got);
        end

        // Reset during MUL_A1 discards the in-flight sample.
        one("prerst", 0, 16'h5A5A, got);
        put(0, 16'h1234);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mrst_data", 32'(bus.data_o), 0);
        check("mrst_valid", 32'(bus.out_valid_o), 0);
        check("mrst_busy", 32'(bus.busy_o), 0);
        check("mrst_ready", 32'(bus.ch_ready_o), 32'hF);
        tick();
        rst = 1'b0;
        mdl_reset();
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.out_valid_o === 1'b1) seen++;
        end
        check("mrst_no_out", seen, 0);
        one("post_rst", 0, 16'h4000, got);
        check("post_rst_lit", 32'(got), 32'h0FFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iir_mux_scheduler.md
Name: iir_mux_scheduler

Overview:
- Time-multiplexed first-order IIR engine for NUM_CH independent audio channels, y[n] = b0·x[n] + b1·x[n-1] − a1·y[n-1].
- One shared 18x18 signed multiplier is sequenced by an FSM. Channels are served round-robin.
- Per-channel history is held in register arrays. Coefficients are runtime-writable through a config port.
- Sits between the per-channel sample sources and the output mixer. Replaces N parallel fixed-coefficient filter instances.

Parameters:
- NUM_CH, 4, number of channels (2..8).
- COEF_B0_RST, 18'sd32767, b0 reset value, Q1.17.
- COEF_B1_RST, -18'sd32768, b1 reset value, Q1.17.
- COEF_A1_RST, 18'sd0, a1 reset value, Q1.17.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- ch_valid_i  in  NUM_CH  per-channel sample strobe.
- ch_data_i  in  NUM_CH*16  per-channel samples, Q1.15 signed; channel k occupies bits [16k+15:16k].
- ch_ready_o  out  NUM_CH  channel k can accept a sample.
- cfg_we_i  in  1  coefficient write strobe.
- cfg_addr_i  in  2  coefficient select: 0=b0, 1=b1, 2=a1, 3=ignored.
- cfg_data_i  in  18  coefficient value, Q1.17 signed.
- clear_i  in  1  pulse; zeroes all channel histories.
- out_valid_o  out  1  one-cycle result strobe.
- out_ch_o  out  $clog2(NUM_CH)  channel of the result.
- data_o  out  16  result, Q1.15 signed.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, any state):
  - FSM → IDLE.
  - pending, xprev[], yprev[], out_valid_o, data_o, out_ch_o, busy_o → 0.
  - Coefficients → *_RST values.
  - RR pointer selects channel 0 first.
- Intake:
  - ch_ready_o[k] = !pending[k].
  - When valid and ready, on that edge: capture x_k = {ch_data_i[k], 2'b00} (18-bit) and set pending[k].
  - Valid while not ready is ignored; the sample is dropped and the source must hold it.
- FSM states: IDLE → MUL_B0 → MUL_B1 → MUL_A1 → SAT → IDLE. One cycle per state.
- IDLE:
  - If any pending, grant the first pending channel at or after rr_ptr (wrapping).
  - Latch the coefficient shadow set (b0, b1, a1).
  - Go to MUL_B0.
  - Otherwise stay in IDLE.
- MUL_B0: acc = (b0·x) >>> 17.
- MUL_B1: acc += (b1·xprev[g]) >>> 17.
- MUL_A1: acc −= (a1·yprev[g]) >>> 17.
- Arithmetic widths:
  - Products are 36-bit signed.
  - The arithmetic shift floors toward −∞.
  - acc is 38-bit signed, with no intermediate saturation.
- SAT:
  - s = clamp(acc, −131072, 131071).
  - Update xprev[g] = x_g, yprev[g] = s.
  - Clear pending[g]; rr_ptr = g+1 mod NUM_CH.
  - Register data_o = s[17:2] and out_ch_o = g.
  - out_valid_o = 1 in the following cycle.
- Latency and throughput:
  - Sample accepted on edge E → out_valid_o high in the cycle after edge E+5.
  - Aggregate throughput: one result per 5 cycles.
- Outputs:
  - data_o and out_ch_o hold their value until the next result.
  - No output backpressure.
- Config:
  - Writes take effect on the live registers immediately.
  - An in-flight computation uses its shadow copy, so a mid-computation write affects only later grants.
  - cfg_addr_i=3 has no effect.
- clear_i:
  - In IDLE: zero all xprev/yprev.
  - While busy: defer until after the SAT write-back. Clear wins over that write-back.
  - Pending samples are kept.
- Same-cycle events:
  - Intake on channel g while g is in SAT is not possible, because ready is low until pending clears.
  - A channel cleared in SAT becomes ready the next cycle.
- Reset mid-computation: no out_valid_o is produced. In-flight and pending samples are discarded.

Test Plan:
- Default coefficients, ch0 x=0x4000 twice → data_o=0x0FFF, then 0xFFFF; out_ch_o=0; 5-cycle latency each.
- Write b0=131071, b1=0, a1=0; ch1 x=0x4000 → data_o=0x3FFF.
- b0=b1=131071, a1=0:
  - x=0x7FFF twice → second result 0x7FFF (positive saturation).
  - Then clear_i, x=0x8000 twice → second result 0x8000 (negative saturation).
- All 4 ch_valid_i asserted in the same cycle → results for ch 0,1,2,3 in order, 5 cycles apart. ch_ready_o[k] stays low until that channel's SAT.
- Write b0=0 during MUL_B1 of a ch2 sample → that result uses the old b0; the next ch2 sample uses 0.
- Assert reset_i during MUL_A1 → outputs 0 immediately, no out_valid_o. After release, ch0 x=0x4000 with default coefficients → 0x0FFF (history cleared).
